udp_packet_id_strip: RTL
========================

# udp_packet_id_strip

Sits downstream of the UDP receive stage, which emits each datagram payload as one AXI-Stream frame prefixed by a 4-byte big-endian packet ID. This block strips the ID, forwards the remaining payload through a one-entry registered output stage, and checks IDs for sequence continuity. It publishes the latest ID and saturating statistics counters for the register map.

## Interface
Parameters:
- ID_BYTES, 4, number of prefix bytes forming the packet ID; fixed at 4 in this revision.

Ports:
- clk  input  1  single clock domain for all logic
- reset  input  1  asynchronous, active-low reset
- in_axis_if  AXIS_IF.Receiver  8-bit tdata, tvalid, tready, tlast  ID-prefixed payload frames from the UDP receive stage
- out_axis_if  AXIS_IF.Transmitter  8-bit tdata, tvalid, tready, tlast  stripped payload
- packet_id  output  32  ID of the most recent accepted frame
- packet_id_valid  output  1  one-cycle pulse when packet_id updates
- frames_ok  output  32  frames forwarded, saturating
- runt_count  output  32  frames dropped for too few bytes, saturating
- gap_count  output  32  forward jumps in ID, saturating
- lost_count  output  32  sum of skipped IDs, saturating
- ooo_count  output  32  repeated or backward IDs, saturating

## Operation
- States: ID, PAYLOAD, DROP.
- ID: in tready is 1. Byte counter 0..3. Shift each byte in MSB-first: id = {id[23:0], tdata}.
- tlast on any ID byte, including byte 3: the frame has no payload. Increment runt_count, return to ID with the counter at 0. The ID register is discarded, and packet_id and the sequence state are unchanged.
- 4th ID byte accepted without tlast:
  - Load packet_id.
  - Pulse packet_id_valid on the next cycle.
  - Run the sequence check.
  - Enter PAYLOAD.
- Sequence check: first ID accepted after reset sets the baseline only. Otherwise compute diff = id − (last_id + 1), mod 2^32.
  - diff = 0: no counter change.
  - 0 < diff < 2^31: gap_count += 1, and lost_count += diff (saturating at 0xFFFFFFFF).
  - diff ≥ 2^31: ooo_count += 1.
  - last_id ← id in all cases.
- PAYLOAD: each accepted input byte is copied to the output register with its tlast. Input tlast returns the FSM to ID and increments frames_ok.
- DROP: reserved for an illegal-state recovery. The FSM consumes bytes with tready=1 until tlast, then returns to ID. The default case of the FSM enters DROP.
- Counter arithmetic: all counters are 32-bit and saturate. lost_count uses a 33-bit sum clamped to 0xFFFFFFFF.

## Timing
- Reset values:
  - FSM in ID, byte counter 0, baseline invalid.
  - out tvalid 0, tdata 0, tlast 0.
  - packet_id 0, packet_id_valid 0, all counters 0.
  - in tready is combinational and is 1 in ID after reset.
- Output stage: registered, one entry. In PAYLOAD, in tready = !out_tvalid || out_tready. A byte accepted in cycle N appears on the output in cycle N+1. Full throughput is one byte per cycle while out_tready stays high.
- out tvalid, tdata and tlast are held stable while tvalid=1 and tready=0.
- In ID and DROP, in tready does not depend on out_tready. The tail of the previous frame may still drain from the output register while the next frame's ID bytes are consumed.
- packet_id_valid and the sequence counters update in the cycle after the 4th ID byte handshake.
- frames_ok updates in the cycle after the input tlast handshake, not the output handshake.
- Simultaneous input and output handshakes in PAYLOAD: the register reloads with no bubble.
- Reset deasserted mid-frame: the block restarts in ID, so the first bytes seen are parsed as an ID. Upstream guarantees frame alignment after reset.

## Test plan
- Single frame, back-to-back:
  - Stimulus: 00 00 00 05 AA BB CC, tlast on CC, out_tready=1.
  - Response: output AA BB CC with tlast on CC, each one cycle after its input.
  - packet_id=0x00000005 with a single packet_id_valid pulse; frames_ok=1; other counters 0.
- Sequence gap:
  - Stimulus: frames with IDs 5, 6, 9, 7, each with a 2-byte payload.
  - Response: gap_count=1, lost_count=2, ooo_count=1, frames_ok=4.
- Wrap-around:
  - Stimulus: IDs 0xFFFFFFFF then 0x00000000.
  - Response: no gap_count or ooo_count change.
- Runts:
  - Stimulus: frame 00 00 01 (tlast on byte 3), then frame 00 00 00 01 (tlast on byte 4).
  - Response: runt_count=2, no output beats, packet_id unchanged, no packet_id_valid pulse.
- Backpressure:
  - Stimulus: 16-byte payload with out_tready toggling randomly, including stalls of 3 cycles.
  - Response: output byte sequence and tlast identical to input; tdata stable during stalls; in tready low only while out_tvalid=1 and out_tready=0.
- Saturation and reset:
  - Stimulus: force lost_count near 0xFFFFFFFF, then send a gap of 0x100.
  - Response: lost_count=0xFFFFFFFF.
  - Stimulus: assert reset mid-payload.
  - Response: all outputs return to reset values immediately, since reset is asynchronous.

Source files
------------

// File: rtl/udp_packet_id_strip.sv
// Strips the 4-byte big-endian packet ID from each frame, checks ID continuity and keeps saturating stats.
// Payload latency 1 cycle via a one-entry output register; in ready follows that register only during payload.
module udp_packet_id_strip #(
    parameter int ID_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_axis_tdata,
    input  logic        in_axis_tvalid,
    output logic        in_axis_tready,
    input  logic        in_axis_tlast,
    output logic [7:0]  out_axis_tdata,
    output logic        out_axis_tvalid,
    input  logic        out_axis_tready,
    output logic        out_axis_tlast,
    output logic [31:0] packet_id,
    output logic        packet_id_valid,
    output logic [31:0] frames_ok,
    output logic [31:0] runt_count,
    output logic [31:0] gap_count,
    output logic [31:0] lost_count,
    output logic [31:0] ooo_count
);

    typedef enum logic [1:0] {
        S_ID      = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    localparam logic [1:0] LAST_ID_BYTE = 2'(ID_BYTES - 1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] id_shift;
    logic [31:0] last_id;
    logic        baseline;
    logic [31:0] id_next;
    logic [31:0] diff;
    logic [32:0] lost_sum;
    logic        in_hs;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        in_axis_tready = 1'b1;
        if (state == S_PAYLOAD)
            in_axis_tready = !out_axis_tvalid || out_axis_tready;
    end

    // diff wraps mod 2^32, so its MSB separates forward gaps from repeats/backward jumps.
    always_comb begin
        in_hs    = in_axis_tvalid && in_axis_tready;
        id_next  = {id_shift[23:0], in_axis_tdata};
        diff     = id_next - (last_id + 32'd1);
        lost_sum = {1'b0, lost_count} + {1'b0, diff};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_ID;
            byte_cnt        <= 2'd0;
            id_shift        <= 32'd0;
            last_id         <= 32'd0;
            baseline        <= 1'b0;
            out_axis_tdata  <= 8'd0;
            out_axis_tvalid <= 1'b0;
            out_axis_tlast  <= 1'b0;
            packet_id       <= 32'd0;
            packet_id_valid <= 1'b0;
            frames_ok       <= 32'd0;
            runt_count      <= 32'd0;
            gap_count       <= 32'd0;
            lost_count      <= 32'd0;
            ooo_count       <= 32'd0;
        end else begin
            packet_id_valid <= 1'b0;
            if (out_axis_tvalid && out_axis_tready)
                out_axis_tvalid <= 1'b0;

            case (state)
                S_ID: begin
                    if (in_hs) begin
                        id_shift <= id_next;
                        if (in_axis_tlast) begin
                            byte_cnt   <= 2'd0;
                            runt_count <= sat_inc(runt_count);
                        end else if (byte_cnt == LAST_ID_BYTE) begin
                            byte_cnt        <= 2'd0;
                            packet_id       <= id_next;
                            packet_id_valid <= 1'b1;
                            last_id         <= id_next;
                            baseline        <= 1'b1;
                            if (baseline && diff != 32'd0) begin
                                if (!diff[31]) begin
                                    gap_count  <= sat_inc(gap_count);
                                    lost_count <= lost_sum[32] ? 32'hFFFF_FFFF : lost_sum[31:0];
                                end else begin
                                    ooo_count <= sat_inc(ooo_count);
                                end
                            end
                            state <= S_PAYLOAD;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (in_hs) begin
                        out_axis_tdata  <= in_axis_tdata;
                        out_axis_tlast  <= in_axis_tlast;
                        out_axis_tvalid <= 1'b1;
                        if (in_axis_tlast) begin
                            state     <= S_ID;
                            frames_ok <= sat_inc(frames_ok);
                        end
                    end
                end
                S_DROP: begin
                    if (in_hs && in_axis_tlast)
                        state <= S_ID;
                end
                default: begin
                    state    <= S_DROP;
                    byte_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule
